// File: rtl/spi_capture_buffer_pkg.sv
// Shared definitions for the SPI capture buffer: default geometry, capture mode
// encoding and the header field layout.
package spi_capture_buffer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 6;
  localparam int BIT_W_DEF  = 4;

  // Header flag positions are offsets below the word MSB, so they track DATA_W.
  localparam int HDR_OVF     = 0;
  localparam int HDR_FULL    = 1;
  localparam int HDR_MODE    = 2;
  localparam int HDR_CNT_LSB = 0;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_CIRC    = 1'b1
  } cap_mode_e;

endpackage

// File: rtl/spi_capture_buffer_if.sv
// Bus bundle between the sample source / SPI front end (master) and the
// capture buffer (slave).
interface spi_capture_buffer_if
  import spi_capture_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [DATA_W-1:0] q;
  logic              write_enable_flag;
  logic              write_reset_flag;
  logic              circ_mode;
  logic              sel;
  logic              valid_flag;
  logic              read_reset_flag;
  logic              so;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;

  modport master (
    output q, write_enable_flag, write_reset_flag, circ_mode,
           sel, valid_flag, read_reset_flag,
    input  so, count, full, overflow
  );

  modport slave (
    input  q, write_enable_flag, write_reset_flag, circ_mode,
           sel, valid_flag, read_reset_flag,
    output so, count, full, overflow
  );
endinterface

// File: rtl/spi_capture_buffer_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read-first read port.
// Contents are never reset.
module scb_dpram
  import spi_capture_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Non-blocking update gives old data on a same-address read/write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rd_data_q <= mem_q[raddr];
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/spi_capture_buffer.sv
// Capture buffer: stores parallel samples, then streams a status header and the
// stored words (oldest first, MSB first) out over SPI.
module spi_capture_buffer
  import spi_capture_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BIT_W  = BIT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_capture_buffer_if.slave  bus
);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   CNT_INC   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_INC   = ADDR_W'(1);
  localparam logic [BIT_W-1:0]  BIT_INC   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  cap_mode_e         mode_q, mode_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              full;
  logic              ram_we;
  logic [DATA_W-1:0] prefetch;
  logic [DATA_W-1:0] header;

  assign full = (count_q == DEPTH_CNT);

  scb_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (bus.q),
    .raddr (rd_addr_q),
    .rdata (prefetch)
  );

  // Write control and status flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mode_d   = mode_q;
    ram_we   = 1'b0;
    if (bus.write_reset_flag) begin
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      mode_d   = cap_mode_e'(bus.circ_mode);
    end else if (bus.write_enable_flag) begin
      if (!full) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_INC;
        count_d  = count_q + CNT_INC;
      end else if (mode_q == MODE_CIRC) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_INC;
        ovf_d    = 1'b1;
      end else begin
        ovf_d    = 1'b1;
      end
    end
  end

  always_comb begin
    header = '0;
    header[DATA_W-1-HDR_OVF]  = ovf_q;
    header[DATA_W-1-HDR_FULL] = full;
    header[DATA_W-1-HDR_MODE] = mode_q;
    header[HDR_CNT_LSB +: ADDR_W+1] = count_q;
  end

  // Serialiser; the header lives in shreg, so later writes cannot disturb it.
  always_comb begin
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    rd_addr_d = rd_addr_q;
    if (bus.read_reset_flag) begin
      shreg_d   = header;
      bit_idx_d = '0;
      rd_addr_d = ((mode_q == MODE_CIRC) && full) ? wr_ptr_q : '0;
    end else if (bus.valid_flag && bus.sel) begin
      if (bit_idx_q == BIT_LAST) begin
        shreg_d   = prefetch;
        bit_idx_d = '0;
        rd_addr_d = rd_addr_q + PTR_INC;
      end else begin
        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
        bit_idx_d = bit_idx_q + BIT_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      rd_addr_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      mode_q    <= mode_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign bus.so       = shreg_q[DATA_W-1];
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.overflow = ovf_q;

endmodule
